// File: rtl/miyamii_pkg.sv
// Shared machine-cycle phase encodings and opcode helpers for the fetch sequencer.
package miyamii_pkg;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  localparam logic [3:0] OP_JCN = 4'h1;
  localparam logic [3:0] OP_FIM = 4'h2;
  localparam logic [3:0] OP_JUN = 4'h4;
  localparam logic [3:0] OP_JMS = 4'h5;
  localparam logic [3:0] OP_ISZ = 4'h7;

  // FIM shares its opr with SRC; only the even-opa form carries a data byte.
  function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
    return (opr == OP_JCN) ||
           ((opr == OP_FIM) && !opa[0]) ||
           (opr == OP_JUN) ||
           (opr == OP_JMS) ||
           (opr == OP_ISZ);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch sequencer bus: PC/stall/ROM nibble in, address nibble, timing and assembled instruction out.
interface instruction_fetch_if;
  logic [11:0] pc_in;
  logic        stall;
  logic [3:0]  bus_in;
  logic [3:0]  bus_out;
  logic        bus_oe;
  logic        sync;
  logic        pc_inc;
  logic [2:0]  cycle_phase;
  logic        instr_valid;
  logic [3:0]  instr_opr;
  logic [3:0]  instr_opa;
  logic [7:0]  instr_arg;
  logic        instr_two_word;
  logic        second_word;

  modport master (
    input  pc_in, stall, bus_in,
    output bus_out, bus_oe, sync, pc_inc, cycle_phase,
           instr_valid, instr_opr, instr_opa, instr_arg, instr_two_word, second_word
  );

  modport slave (
    output pc_in, stall, bus_in,
    input  bus_out, bus_oe, sync, pc_inc, cycle_phase,
           instr_valid, instr_opr, instr_opa, instr_arg, instr_two_word, second_word
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch sequencer: 8-phase machine cycle, nibble-multiplexed ROM address/data,
// one- and two-byte instruction assembly.
//
// state | meaning
// A1    | drive addr[3:0], sync high
// A2    | drive addr[7:4]
// A3    | drive addr[11:8]
// M1    | capture opcode high nibble (or arg[7:4])
// M2    | capture low nibble (or arg[3:0]), pc_inc strobe
// X1    | instr_valid strobe for a completed instruction
// X2    | execute slot
// X3    | latch next fetch address, advance second_word
module instruction_fetch
  import miyamii_pkg::*;
#(
  parameter logic [11:0] RESET_VECTOR = 12'h000
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master fif
);

  phase_t      phase;
  phase_t      phase_nxt;
  logic        adv;
  logic [11:0] fetch_addr;
  logic [3:0]  hi_cap;
  logic [3:0]  first_opr;
  logic [3:0]  first_opa;
  logic        pend_two;
  logic        second_word;
  logic        instr_valid;
  logic [3:0]  instr_opr;
  logic [3:0]  instr_opa;
  logic [7:0]  instr_arg;
  logic        instr_two_word;
  logic        first_is_two;

  assign adv          = !fif.stall;
  assign first_is_two = is_two_word(hi_cap, fif.bus_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= PH_A1;
    end else if (adv) begin
      phase <= phase_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase_t'(phase + 3'd1);
  end

  always_comb begin
    fif.bus_out = 4'h0;
    fif.bus_oe  = 1'b0;
    fif.sync    = 1'b0;
    unique case (phase)
      PH_A1: begin
        fif.bus_out = fetch_addr[3:0];
        fif.bus_oe  = 1'b1;
        fif.sync    = 1'b1;
      end
      PH_A2: begin
        fif.bus_out = fetch_addr[7:4];
        fif.bus_oe  = 1'b1;
      end
      PH_A3: begin
        fif.bus_out = fetch_addr[11:8];
        fif.bus_oe  = 1'b1;
      end
      default: begin
        fif.bus_out = 4'h0;
      end
    endcase
    fif.pc_inc      = (phase == PH_M2) && adv;
    fif.cycle_phase = phase;
  end

  // Address is latched only at the cycle boundary so PC updates during the
  // cycle never disturb the nibbles already being driven.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_addr  <= RESET_VECTOR;
      hi_cap      <= 4'h0;
      first_opr   <= 4'h0;
      first_opa   <= 4'h0;
      pend_two    <= 1'b0;
      second_word <= 1'b0;
    end else if (adv) begin
      if (phase == PH_M1) begin
        hi_cap <= fif.bus_in;
      end
      if ((phase == PH_M2) && !second_word && first_is_two) begin
        first_opr <= hi_cap;
        first_opa <= fif.bus_in;
        pend_two  <= 1'b1;
      end
      if (phase == PH_X3) begin
        fetch_addr  <= fif.pc_in;
        second_word <= pend_two;
        pend_two    <= 1'b0;
      end
    end
  end

  // Valid rises on the M2->X1 edge and falls on the X1->X2 edge; a stall in
  // X1 therefore stretches the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid    <= 1'b0;
      instr_opr      <= 4'h0;
      instr_opa      <= 4'h0;
      instr_arg      <= 8'h00;
      instr_two_word <= 1'b0;
    end else if (adv) begin
      instr_valid <= (phase == PH_M2) && (second_word || !first_is_two);
      if (phase == PH_M2) begin
        if (second_word) begin
          instr_opr      <= first_opr;
          instr_opa      <= first_opa;
          instr_arg      <= {hi_cap, fif.bus_in};
          instr_two_word <= 1'b1;
        end else if (!first_is_two) begin
          instr_opr      <= hi_cap;
          instr_opa      <= fif.bus_in;
          instr_arg      <= 8'h00;
          instr_two_word <= 1'b0;
        end
      end
    end
  end

  assign fif.second_word    = second_word;
  assign fif.instr_valid    = instr_valid;
  assign fif.instr_opr      = instr_opr;
  assign fif.instr_opa      = instr_opa;
  assign fif.instr_arg      = instr_arg;
  assign fif.instr_two_word = instr_two_word;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: expected instructions are queued as
// ROM bytes are served and checked when instr_valid appears in X1.
module tb_instruction_fetch;
  import miyamii_pkg::*;

  typedef struct packed {
    logic [3:0] opr;
    logic [3:0] opa;
    logic [7:0] arg;
    logic       two;
  } instr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetch_if fif ();

  instruction_fetch #(.RESET_VECTOR(12'h000)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  instr_t exp_q[$];
  int     n_assert   = 0;
  int     n_fail     = 0;
  int     pc_inc_cnt = 0;

  always @(posedge clk) if (fif.pc_inc === 1'b1) pc_inc_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] op, input logic [7:0] arg, input logic two);
    instr_t e;
    e.opr = op[7:4];
    e.opa = op[3:0];
    e.arg = arg;
    e.two = two;
    exp_q.push_back(e);
  endtask

  // Call while in A1 away from the edge; returns in the following A1.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_phase", fif.cycle_phase, PH_A1);
    chk("rst_sync", fif.sync, 1'b1);
    chk("rst_oe", fif.bus_oe, 1'b1);
    chk("rst_bus", fif.bus_out, 4'h0);
    chk("rst_valid", fif.instr_valid, 1'b0);
    chk("rst_sw", fif.second_word, 1'b0);
    chk("rst_inc", fif.pc_inc, 1'b0);
    chk("rst_instr", {fif.instr_opr, fif.instr_opa, fif.instr_arg, fif.instr_two_word}, 17'h0);
    rst = 1'b0;
    #1;
  endtask

  task automatic mcycle(input logic [7:0] b, input logic [11:0] a, input logic sw, input logic v,
                        input logic [11:0] pc_a2, input logic [11:0] pc_x2,
                        input int stall_m2, input int stall_x1);
    int     c0;
    instr_t e;
    c0 = pc_inc_cnt;
    chk("a1_phase", fif.cycle_phase, PH_A1);
    chk("a1_sync", fif.sync, 1'b1);
    chk("a1_oe", fif.bus_oe, 1'b1);
    chk("a1_bus", fif.bus_out, a[3:0]);
    chk("a1_sw", fif.second_word, sw);
    chk("a1_inc", fif.pc_inc, 1'b0);
    tick();
    chk("a2_phase", fif.cycle_phase, PH_A2);
    chk("a2_sync", fif.sync, 1'b0);
    chk("a2_bus", fif.bus_out, a[7:4]);
    fif.pc_in = pc_a2;
    tick();
    chk("a3_phase", fif.cycle_phase, PH_A3);
    chk("a3_oe", fif.bus_oe, 1'b1);
    chk("a3_bus", fif.bus_out, a[11:8]);
    fif.bus_in = b[7:4];
    tick();
    chk("m1_phase", fif.cycle_phase, PH_M1);
    chk("m1_oe", fif.bus_oe, 1'b0);
    chk("m1_bus", fif.bus_out, 4'h0);
    chk("m1_inc", fif.pc_inc, 1'b0);
    tick();
    chk("m2_phase", fif.cycle_phase, PH_M2);
    if (stall_m2 > 0) begin
      fif.stall  = 1'b1;
      fif.bus_in = ~b[3:0];
      #1;
      for (int i = 0; i < stall_m2; i++) begin
        chk("stall_inc", fif.pc_inc, 1'b0);
        tick();
        chk("stall_phase", fif.cycle_phase, PH_M2);
      end
      fif.stall = 1'b0;
    end
    fif.bus_in = b[3:0];
    #1;
    chk("m2_inc", fif.pc_inc, 1'b1);
    tick();
    chk("x1_phase", fif.cycle_phase, PH_X1);
    chk("x1_valid", fif.instr_valid, v);
    if (v) begin
      chk("x1_queue_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("x1_opr", fif.instr_opr, e.opr);
        chk("x1_opa", fif.instr_opa, e.opa);
        chk("x1_arg", fif.instr_arg, e.arg);
        chk("x1_two_word", fif.instr_two_word, e.two);
      end
    end
    if (stall_x1 > 0) begin
      fif.stall = 1'b1;
      for (int i = 0; i < stall_x1; i++) begin
        tick();
        chk("x1_stall_phase", fif.cycle_phase, PH_X1);
        chk("x1_stall_valid", fif.instr_valid, v);
      end
      fif.stall = 1'b0;
    end
    tick();
    chk("x2_phase", fif.cycle_phase, PH_X2);
    chk("x2_valid", fif.instr_valid, 1'b0);
    fif.pc_in = pc_x2;
    tick();
    chk("x3_phase", fif.cycle_phase, PH_X3);
    tick();
    chk("cycle_inc_count", pc_inc_cnt - c0, 1);
  endtask

  initial begin
    int c_jun;
    rst        = 1'b1;
    fif.pc_in  = 12'h000;
    fif.stall  = 1'b0;
    fif.bus_in = 4'h0;
    tick();
    tick();

    // single-byte opcode from the reset vector
    do_reset();
    fif.pc_in = 12'h001;
    push(8'hD5, 8'h00, 1'b0);
    mcycle(8'hD5, 12'h000, 1'b0, 1'b1, 12'h001, 12'h001, 0, 0);

    // JUN 43 21
    do_reset();
    fif.pc_in = 12'h001;
    c_jun = pc_inc_cnt;
    mcycle(8'h43, 12'h000, 1'b0, 1'b0, 12'h001, 12'h001, 0, 0);
    push(8'h43, 8'h21, 1'b1);
    mcycle(8'h21, 12'h001, 1'b1, 1'b1, 12'h002, 12'h002, 0, 0);
    chk("jun_inc_total", pc_inc_cnt - c_jun, 2);
    chk("jun_sw_clear", fif.second_word, 1'b0);

    // SRC (odd opa) is single-word, FIM (even opa) is two-word
    push(8'h21, 8'h00, 1'b0);
    mcycle(8'h21, 12'h002, 1'b0, 1'b1, 12'h003, 12'h003, 0, 0);
    mcycle(8'h20, 12'h003, 1'b0, 1'b0, 12'h004, 12'h004, 0, 0);
    push(8'h20, 8'h5A, 1'b1);
    mcycle(8'h5A, 12'h004, 1'b1, 1'b1, 12'h005, 12'h005, 0, 0);

    // stall held three clocks in M2, then one clock in X1
    push(8'hB7, 8'h00, 1'b0);
    mcycle(8'hB7, 12'h005, 1'b0, 1'b1, 12'h006, 12'h006, 3, 1);

    // PC changes: in X2 it redirects the next fetch, in A2 it is ignored
    push(8'hE2, 8'h00, 1'b0);
    mcycle(8'hE2, 12'h006, 1'b0, 1'b1, 12'h007, 12'hABC, 0, 0);
    push(8'h69, 8'h00, 1'b0);
    mcycle(8'h69, 12'hABC, 1'b0, 1'b1, 12'h123, 12'h124, 0, 0);
    push(8'hF0, 8'h00, 1'b0);
    mcycle(8'hF0, 12'h124, 1'b0, 1'b1, 12'h125, 12'h125, 0, 0);

    // reset in M1 of a second-byte cycle drops the pending JMS
    mcycle(8'h50, 12'h125, 1'b0, 1'b0, 12'h126, 12'h126, 0, 0);
    fif.bus_in = 4'h3;
    tick();
    tick();
    tick();
    chk("pre_rst_phase", fif.cycle_phase, PH_M1);
    chk("pre_rst_sw", fif.second_word, 1'b1);
    fif.pc_in = 12'h001;
    do_reset();
    push(8'hD5, 8'h00, 1'b0);
    mcycle(8'hD5, 12'h000, 1'b0, 1'b1, 12'h001, 12'h001, 0, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch sequencer that sits directly downstream of the program counter/stack block. It consumes the 12-bit PC and issues it to program ROM as three nibbles over the 4-bit multiplexed bus. It reads back the 8-bit opcode as two nibbles and assembles one- or two-byte instructions for the decoder. It generates the PC increment strobe and the 8-phase machine-cycle timing (A1 A2 A3 M1 M2 X1 X2 X3).

Parameters:
RESET_VECTOR, 12'h000, address loaded into the fetch address register on reset; first fetch uses it.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
pc_in  input  12  current PC from program counter/stack block
stall  input  1  freezes phase counter and all state while high
bus_in  input  4  ROM data nibble
bus_out  output  4  address nibble driven to ROM
bus_oe  output  1  bus_out valid/drive enable
sync  output  1  high during A1 of every machine cycle
pc_inc  output  1  one-cycle PC increment strobe
cycle_phase  output  3  current phase, 0=A1 … 7=X3
instr_valid  output  1  one-cycle strobe: complete instruction available
instr_opr  output  4  opcode high nibble
instr_opa  output  4  opcode low nibble
instr_arg  output  8  second byte (0 for single-word)
instr_two_word  output  1  instruction is two bytes
second_word  output  1  current machine cycle fetches second byte

Behaviour:
- Reset (async, any phase): phase=A1, fetch address reg=RESET_VECTOR, opr/opa/arg=0, second_word=0, instr_valid=0, instr_two_word=0, pc_inc=0. Outputs derived from phase follow immediately: sync=1, bus_oe=1, bus_out=RESET_VECTOR[3:0].
- Phase advances by one per clk when stall=0 and wraps X3→A1. stall=1 holds phase and every register, and forces pc_inc=0.
- A1/A2/A3: bus_out = addr[3:0], addr[7:4], addr[11:8] respectively. bus_oe=1 only in A1–A3, else bus_out=0.
- M1: capture bus_in at the clk edge ending M1 (opcode high nibble, or arg[7:4] if second_word).
- M2: capture bus_in (low nibble, or arg[3:0]). pc_inc=1 for exactly the M2 cycle (combinational on phase==M2 && !stall), so exactly one pulse per machine cycle.
- X1 two-word decode on first byte: opr=1 (JCN), opr=2 with opa[0]=0 (FIM), opr=4 (JUN), opr=5 (JMS), opr=7 (ISZ).
  - Two-word first byte: set second_word for the next machine cycle, no instr_valid.
  - Otherwise instr_valid=1 during X1 (registered on M2→X1 edge), with opr/opa/arg and instr_two_word stable from X1 until the next X1 strobe.
  - Second-byte cycle: instr_valid in its X1, instr_two_word=1, second_word cleared at its X3→A1 edge.
- Address latch: fetch address reg loads pc_in at the X3→A1 edge, so pc_in changes in A1–X2 never corrupt the current fetch. The execution unit's PC load/push/pop issued by X2 is fetched next cycle.
- Latency: first instr_valid 5 clocks after reset release (A1..M2, strobe in X1) with no stall.
- Stall in X1 extends the instr_valid pulse; the decoder must qualify with !stall.
- Reset during second_word cycle discards the pending first byte.

Decomposition:
- Shared package miyamii_pkg holds the phase encodings (PH_A1..PH_X3), opcode constants OP_JCN/OP_FIM/OP_JUN/OP_JMS/OP_ISZ, and function is_two_word(opr,opa).
- No sub-module. Phase counter, nibble mux and capture regs stay inline in instruction_fetch.

Test Plan:
1. Reset release, RESET_VECTOR=0, bus_in M1=D M2=5 → bus_out 0,0,0 in A1–A3; pc_inc only in M2; X1 instr_valid, opr=D opa=5 arg=00 two_word=0.
2. JUN: bytes 43 then 21 at pc 000/001 → no valid in first X1; second cycle bus_out 1,0,0, second_word=1; X1 instr_valid opr=4 opa=3 arg=21 two_word=1; two pc_inc pulses total.
3. Opcode 21 (SRC, opa odd) → single-word valid in first X1. Opcode 20 (FIM) → two-word.
4. stall=1 for 3 clks entering M2 → phase stays M2, pc_inc low while stalled, exactly one pc_inc pulse after release, capture value taken at release edge.
5. pc_in changed to ABC during X2 → next A1/A2/A3 bus_out C,B,A. pc_in changed to 123 during A2 → current bus_out unaffected.
6. rst pulsed mid-M1 of second-word cycle → immediately phase=A1, second_word=0, instr_valid=0, bus_out=RESET_VECTOR[3:0]. Normal fetch from RESET_VECTOR resumes.
